shared_expr_sequencer: RTL and testbench

Multi-cycle, resource-shared evaluator for the six-output expression datapath. It computes s1 = a+b, s2 = a*b, s3 = (a mod b)+d, s4 = c+d+s2, s5 = a−b and s6 = s4+s5. One shift-add multiplier and one restoring remainder unit are shared and sequenced by an FSM, replacing the combinational multiplier and modulo units. It sits between an operand producer and a result consumer and is driven by a start/busy/done handshake.

---
 rtl/shared_expr_sequencer.sv | 168 ++++++++++++++++
 tb/tb_shared_expr_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shared_expr_sequencer.sv
// shared_expr_sequencer
//   Multi-cycle evaluator for the six-output expression datapath:
//     s1 = a+b, s2 = a*b, s3 = (a mod b)+d, s4 = c+d+s2, s5 = a-b, s6 = s4+s5
//   A single shift-add multiplier (MUL, BW cycles, LSB first) and a single
//   restoring remainder unit (MOD, BW cycles, MSB first) are time-shared by
//   the FSM IDLE -> MUL -> MOD -> FIN -> IDLE. All arithmetic wraps mod 2^BW.
//
// Ports
//   clk                : clock, rising edge
//   rst                : asynchronous reset, active-high
//   start              : request, sampled only while busy=0
//   a, b, c, d [BW]    : operands, latched on the accepting edge
//   busy               : high from the accepting edge until the done cycle
//   done               : one-cycle pulse, results valid from this cycle on
//   s1..s6 [BW]        : registered results, held until the next done
//
// Configuration
//   SEQ_ZERO_SKIP_EN   : when defined, a request with b=0 goes straight to FIN
//                        (acc=0, r=a); results are identical to the full path.
module shared_expr_sequencer #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] c,
  input  logic [BW-1:0] d,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] s1,
  output logic [BW-1:0] s2,
  output logic [BW-1:0] s3,
  output logic [BW-1:0] s4,
  output logic [BW-1:0] s5,
  output logic [BW-1:0] s6
);

  localparam int CW = $clog2(BW);
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  typedef enum logic [1:0] {IDLE, MUL, MOD, FIN} state_t;

  state_t        r_state;
  state_t        w_next;

  logic [BW-1:0] r_a, r_b, r_c, r_d;
  logic [BW-1:0] r_acc;
  logic [BW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [BW-1:0] r_s1, r_s2, r_s3, r_s4, r_s5, r_s6;

  logic          w_accept;
  logic          w_last;
  logic          w_skip;
  logic [BW:0]   w_rem_shift;
  logic [BW-1:0] w_rem_sub;
  logic [BW-1:0] w_rem_next;
  logic [BW-1:0] w_s4;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == LAST);

`ifdef SEQ_ZERO_SKIP_EN
  assign w_skip = (b == '0);
`else
  assign w_skip = 1'b0;
`endif

  // Restoring step: shift in the next dividend bit (MSB first) into a BW+1
  // bit partial remainder, subtract the divisor if it fits. The subtraction
  // result is always < b, so BW bits hold it. With b=0 the compare always
  // passes and nothing is subtracted, leaving r = a (bvurem semantics).
  assign w_rem_shift = {r_rem, r_a[LAST - r_cnt]};
  assign w_rem_sub   = w_rem_shift[BW-1:0] - r_b;
  assign w_rem_next  = (w_rem_shift >= {1'b0, r_b}) ? w_rem_sub : w_rem_shift[BW-1:0];

  assign w_s4 = r_c + r_d + r_acc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = w_skip ? FIN : MUL;
      MUL:  if (w_last) w_next = MOD;
      MOD:  if (w_last) w_next = FIN;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (r_state != IDLE);
    done = r_done;
    s1   = r_s1;
    s2   = r_s2;
    s3   = r_s3;
    s4   = r_s4;
    s5   = r_s5;
    s6   = r_s6;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_d    <= '0;
      r_acc  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_s4   <= '0;
      r_s5   <= '0;
      r_s6   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= c;
            r_d   <= d;
            r_s1  <= a + b;
            r_s5  <= a - b;
            r_acc <= '0;
            r_cnt <= '0;
            // Skipped requests enter FIN directly, so preload the remainder
            // with the value the full algorithm would reach for b=0.
            r_rem <= w_skip ? a : '0;
          end
        end
        MUL: begin
          if (r_b[r_cnt]) r_acc <= r_acc + (r_a << r_cnt);
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        MOD: begin
          r_rem <= w_rem_next;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        FIN: begin
          r_s2   <= r_acc;
          r_s3   <= r_rem + r_d;
          r_s4   <= w_s4;
          // s6 uses the freshly computed s4, not the value still in r_s4
          r_s6   <= w_s4 + r_s5;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_expr_sequencer.sv
module tb_shared_expr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b, c, d;
  logic       busy, done;
  logic [7:0] s1, s2, s3, s4, s5, s6;

  int total = 0;
  int bad   = 0;

`ifdef SEQ_ZERO_SKIP_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 17;
`endif

  shared_expr_sequencer #(.BW(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int e1, input int e2, input int e3,
                           input int e4, input int e5, input int e6);
    chk({tag, "_s1"}, 32'(s1), e1);
    chk({tag, "_s2"}, 32'(s2), e2);
    chk({tag, "_s3"}, 32'(s3), e3);
    chk({tag, "_s4"}, 32'(s4), e4);
    chk({tag, "_s5"}, 32'(s5), e5);
    chk({tag, "_s6"}, 32'(s6), e6);
  endtask

  // Counts rising edges until done is seen (sampled 1 time unit after each
  // edge); bounded so a missing done shows up as a wrong latency.
  task automatic wait_done(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) found = 1'b1;
    end
  endtask

  task automatic run_req(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic [7:0] id,
                         input int e1, input int e2, input int e3,
                         input int e4, input int e5, input int e6, input int lat);
    int n;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    // operands move while busy; must have no effect
    a = ~ia; b = ib + 8'd3; c = ~ic; d = id ^ 8'h5a;
    wait_done(n);
    chk({tag, "_lat"}, n, lat);
    check_res(tag, e1, e2, e3, e4, e5, e6);
    chk({tag, "_busy_done"}, 32'(busy), 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  logic [7:0] ta[3]  = '{8'd7, 8'd200, 8'd13};
  logic [7:0] tb_[3] = '{8'd3, 8'd100, 8'd5};
  logic [7:0] tc[3]  = '{8'd2, 8'd250, 8'd4};
  logic [7:0] td[3]  = '{8'd5, 8'd10, 8'd6};
  int x1[3] = '{10, 44, 18};
  int x2[3] = '{21, 32, 65};
  int x3[3] = '{6, 10, 9};
  int x4[3] = '{28, 36, 75};
  int x5[3] = '{4, 100, 8};
  int x6[3] = '{32, 136, 83};

  initial begin
    int n;
    int pulses;
    int dn;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0; d = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    check_res("rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic, wrap-around, divisor zero, a<b
    run_req("basic", 8'd7, 8'd3, 8'd2, 8'd5, 10, 21, 6, 28, 4, 32, 17);
    run_req("wrap", 8'd200, 8'd100, 8'd250, 8'd10, 44, 32, 10, 36, 100, 136, 17);
    run_req("bzero", 8'd9, 8'd0, 8'd1, 8'd2, 9, 0, 11, 3, 9, 12, LAT_ZERO);
    run_req("altb", 8'd5, 8'd9, 8'd0, 8'd255, 14, 45, 4, 44, 252, 40, 17);

    // start pulsed again at cycle 5 of an active request is ignored
    @(negedge clk);
    a = 8'd7; b = 8'd3; c = 8'd2; d = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a = 8'd200; b = 8'd100; c = 8'd250; d = 8'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 5; pulses = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        pulses++;
        dn = n;
        if (pulses == 1) check_res("ign", 10, 21, 6, 28, 4, 32);
      end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_lat", dn, 17);
    chk("ign_busy", 32'(busy), 0);

    // Reset in the middle of a request aborts it
    @(negedge clk);
    a = 8'd13; b = 8'd5; c = 8'd4; d = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy_async", 32'(busy), 0);
    check_res("abort_async", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    check_res("abort_hold", 0, 0, 0, 0, 0, 0);
    run_req("post_rst", 8'd13, 8'd5, 8'd4, 8'd6, 18, 65, 9, 75, 8, 83, 17);

    // start held high for three back-to-back requests; the next request is
    // accepted at the edge that closes each done cycle
    @(negedge clk);
    a = ta[0]; b = tb_[0]; c = tc[0]; d = td[0]; start = 1'b1;
    @(posedge clk); #1;
    a = ta[1]; b = tb_[1]; c = tc[1]; d = td[1];
    for (int k = 0; k < 3; k++) begin
      wait_done(n);
      chk($sformatf("b2b%0d_lat", k), n, 17);
      check_res($sformatf("b2b%0d", k), x1[k], x2[k], x3[k], x4[k], x5[k], x6[k]);
      if (k == 2) begin
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_accept", k + 1), 32'(busy), 1);
        if (k == 0) begin
          a = ta[2]; b = tb_[2]; c = tc[2]; d = td[2];
        end
      end
    end
    @(posedge clk); #1;
    chk("b2b_end_busy", 32'(busy), 0);
    chk("b2b_end_done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
